// File: rtl/prio_codec_pkg.sv
// Shared types for the priority encode/decode channel: index/one-hot widths and decoder states.
package prio_codec_pkg;

    localparam int PRIO_IDX_W = 2;
    localparam int PRIO_LINES = 4;
    localparam int PRIO_CNT_W = 8;

    typedef logic [PRIO_IDX_W-1:0] prio_idx_t;
    typedef logic [PRIO_LINES-1:0] prio_onehot_t;
    typedef logic [PRIO_CNT_W-1:0] prio_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } prio_dec_state_t;

endpackage

// File: rtl/priority_decoder_2to4_dec2to4.sv
// Purpose: combinational 2-bit index to 4-line one-hot.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the parent registers the result.
module dec2to4
    import prio_codec_pkg::*;
(
    input  prio_idx_t    i_idx,
    output prio_onehot_t o_onehot
);

    always_comb begin
        o_onehot = '0;
        case (i_idx)
            2'd0:    o_onehot = 4'b0001;
            2'd1:    o_onehot = 4'b0010;
            2'd2:    o_onehot = 4'b0100;
            2'd3:    o_onehot = 4'b1000;
            default: o_onehot = '0;
        endcase
    end

endmodule

// File: rtl/priority_decoder_2to4.sv
// Purpose: turn an accepted priority index back into a one-hot strobe held HOLD_CYCLES, then a GAP_CYCLES quiet gap.
// Latency: one-hot valid the cycle after accept; done on the last drive cycle.
// Backpressure: in_ready only in IDLE outside reset; nothing is queued while busy.
module priority_decoder_2to4
    import prio_codec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  prio_idx_t    in_idx,
    output logic         in_ready,
    output prio_onehot_t out_onehot,
    output logic         out_valid,
    output logic         done
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("priority_decoder_2to4: HOLD_CYCLES must be 1..255");
        end
        if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
            $error("priority_decoder_2to4: GAP_CYCLES must be 0..255");
        end
    endgenerate

    localparam prio_cnt_t HOLD_LOAD = PRIO_CNT_W'(HOLD_CYCLES - 1);
    localparam prio_cnt_t GAP_LOAD  = (GAP_CYCLES > 0) ? PRIO_CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit        HAS_GAP   = (GAP_CYCLES > 0);

    prio_dec_state_t r_state;
    prio_dec_state_t w_state_nxt;
    prio_cnt_t       r_cnt;
    prio_cnt_t       w_cnt_nxt;
    prio_idx_t       r_idx;
    prio_onehot_t    r_onehot;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_cnt_zero;
    prio_idx_t       w_dec_idx;
    prio_onehot_t    w_dec_onehot;

    assign in_ready   = (r_state == IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_zero = (r_cnt == '0);

    // Fresh code on the accept edge, otherwise the captured one keeps the line stable.
    assign w_dec_idx = w_accept ? in_idx : r_idx;

    dec2to4 u_dec (
        .i_idx    (w_dec_idx),
        .o_onehot (w_dec_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = DRIVE;
                    w_cnt_nxt   = HOLD_LOAD;
                end
            end
            DRIVE: begin
                if (w_cnt_zero) begin
                    if (HAS_GAP) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_onehot    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            if (w_accept) begin
                r_idx <= in_idx;
            end
            r_onehot    <= (w_state_nxt == DRIVE) ? w_dec_onehot : '0;
            r_out_valid <= (w_state_nxt == DRIVE);
        end
    end

    assign out_onehot = r_onehot;
    assign out_valid  = r_out_valid;
    assign done       = (r_state == DRIVE) && w_cnt_zero;

endmodule
